// File: rtl/oled_pkg.sv
`default_nettype none
// ============================================================================
// oled_pkg : shared SSD1306 command/DC encodings and FSM state type
// Revision : 1.0
// ============================================================================
package oled_pkg;

  localparam logic [7:0] CMD_PAGE   = 8'hB0;
  localparam logic [7:0] CMD_COL_LO = 8'h00;
  localparam logic [7:0] CMD_COL_HI = 8'h10;

  localparam logic DC_CMD  = 1'b0;
  localparam logic DC_DATA = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_RD   = 3'd2,
    ST_SEND = 3'd3,
    ST_WAIT = 3'd4,
    ST_ADV  = 3'd5,
    ST_FIN  = 3'd6
  } state_e;

  function automatic logic [9:0] mk_word(input logic dc, input logic [7:0] b);
    return {1'b0, dc, b};
  endfunction

endpackage
`default_nettype wire

// File: rtl/oled_refresh.sv
`default_nettype none
// ============================================================================
// oled_refresh : streams the GRAM frame buffer to the SPI shifter page by page
// Revision     : 1.0
// ============================================================================
module oled_refresh #(
  parameter int PAGES      = 8,
  parameter int COLS       = 128,
  parameter int COL_OFFSET = 0,
  parameter int AW         = 10
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          START,
  output logic          BUSY,
  output logic          DONE,
  output logic [AW-1:0] gram_addr,
  input  logic [7:0]    gram_data,
  output logic          spi_start,
  input  logic          spi_done,
  output logic [9:0]    spi_data
);
  import oled_pkg::*;

  localparam int PW = (PAGES > 1) ? $clog2(PAGES) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [PW-1:0] LAST_PAGE = PW'(PAGES - 1);
  localparam logic [CW-1:0] LAST_COL  = CW'(COLS - 1);
  localparam logic [7:0]    COL_OFF   = 8'(COL_OFFSET);
  localparam logic [1:0]    HDR_LAST  = 2'd2;
  // hdr_idx parks at 3 while the data bytes of a page are streaming
  localparam logic [1:0]    HDR_DATA  = 2'd3;

  state_e        state_q, state_d;
  logic [PW-1:0] page_q, page_d;
  logic [CW-1:0] col_q, col_d;
  logic [1:0]    hdr_idx_q, hdr_idx_d;
  logic          rd_wait_q, rd_wait_d;
  logic [9:0]    spi_data_q, spi_data_d;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ST_IDLE;
      page_q    <= '0;
      col_q     <= '0;
      hdr_idx_q <= '0;
      rd_wait_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      page_q    <= page_d;
      col_q     <= col_d;
      hdr_idx_q <= hdr_idx_d;
      rd_wait_q <= rd_wait_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    page_d    = page_q;
    col_d     = col_q;
    hdr_idx_d = hdr_idx_q;
    rd_wait_d = rd_wait_q;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_d   = ST_HDR;
          page_d    = '0;
          col_d     = '0;
          hdr_idx_d = '0;
        end
      end
      ST_HDR:  state_d = ST_SEND;
      ST_RD: begin
        // first cycle presents the address, second cycle sees the RAM data
        rd_wait_d = ~rd_wait_q;
        if (rd_wait_q) state_d = ST_SEND;
      end
      ST_SEND: state_d = ST_WAIT;
      ST_WAIT: begin
        if (spi_done) state_d = ST_ADV;
      end
      ST_ADV: begin
        if (hdr_idx_q < HDR_LAST) begin
          hdr_idx_d = hdr_idx_q + 2'd1;
          state_d   = ST_HDR;
        end else if (hdr_idx_q == HDR_LAST) begin
          hdr_idx_d = HDR_DATA;
          col_d     = '0;
          state_d   = ST_RD;
        end else if (col_q != LAST_COL) begin
          col_d   = col_q + CW'(1);
          state_d = ST_RD;
        end else if (page_q != LAST_PAGE) begin
          page_d    = page_q + PW'(1);
          col_d     = '0;
          hdr_idx_d = '0;
          state_d   = ST_HDR;
        end else begin
          state_d = ST_FIN;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    spi_data_d = spi_data_q;
    case (state_q)
      ST_HDR: begin
        case (hdr_idx_q)
          2'd0:    spi_data_d = mk_word(DC_CMD, CMD_PAGE | 8'(page_q));
          2'd1:    spi_data_d = mk_word(DC_CMD, CMD_COL_LO | {4'h0, COL_OFF[3:0]});
          default: spi_data_d = mk_word(DC_CMD, CMD_COL_HI | {4'h0, COL_OFF[7:4]});
        endcase
      end
      ST_RD: begin
        if (rd_wait_q) spi_data_d = mk_word(DC_DATA, gram_data);
      end
      default: spi_data_d = spi_data_q;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) spi_data_q <= '0;
    else        spi_data_q <= spi_data_d;
  end

  assign gram_addr = AW'(page_q) * AW'(COLS) + AW'(col_q);
  assign spi_data  = spi_data_q;
  assign spi_start = (state_q == ST_SEND);
  assign DONE      = (state_q == ST_FIN);
  assign BUSY      = (state_q != ST_IDLE) && (state_q != ST_FIN);

endmodule
`default_nettype wire

// File: tb/tb_oled_refresh.sv
`default_nettype none
// ============================================================================
// tb_oled_refresh : directed checks of the frame streamer (default and offset 2)
// Revision        : 1.0
// ============================================================================
module tb_oled_refresh;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       START0 = 1'b0, START1 = 1'b0, stray_en = 1'b0;
  logic       BUSY0, DONE0, spi_start0, spi_done0;
  logic       BUSY1, DONE1, spi_start1, spi_done1;
  logic [9:0] gram_addr0, spi_data0, gram_addr1, spi_data1;
  logic [7:0] gram_data0 = 8'h0, gram_data1 = 8'h0;
  logic       done_m0 = 1'b0, d1_0 = 1'b0, d2_0 = 1'b0, done_m1 = 1'b0;
  int         cnt0 = 0, cnt1 = 0;

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  oled_refresh u_dut0 (
    .CLK(CLK), .RST_N(RST_N), .START(START0), .BUSY(BUSY0), .DONE(DONE0),
    .gram_addr(gram_addr0), .gram_data(gram_data0), .spi_start(spi_start0),
    .spi_done(spi_done0), .spi_data(spi_data0)
  );

  oled_refresh #(.COL_OFFSET(2)) u_dut1 (
    .CLK(CLK), .RST_N(RST_N), .START(START1), .BUSY(BUSY1), .DONE(DONE1),
    .gram_addr(gram_addr1), .gram_data(gram_data1), .spi_start(spi_start1),
    .spi_done(spi_done1), .spi_data(spi_data1)
  );

  // GRAM models: 1-cycle synchronous read
  always @(posedge CLK) gram_data0 <= gram_addr0[7:0] ^ 8'h5A;
  always @(posedge CLK) gram_data1 <= gram_addr1[7:0] ^ 8'h5A;

  // SPI models: spi_done 20 cycles after spi_start
  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt0 <= 0; done_m0 <= 1'b0; d1_0 <= 1'b0; d2_0 <= 1'b0;
    end else begin
      done_m0 <= (cnt0 == 1);
      if (spi_start0)     cnt0 <= 19;
      else if (cnt0 != 0) cnt0 <= cnt0 - 1;
      d1_0 <= done_m0;
      d2_0 <= d1_0;
    end
  end
  // stray pulses land in SEND and two cycles after a real done (HDR or RD)
  assign spi_done0 = done_m0 | (stray_en & (d2_0 | spi_start0));

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt1 <= 0; done_m1 <= 1'b0;
    end else begin
      done_m1 <= (cnt1 == 1);
      if (spi_start1)     cnt1 <= 19;
      else if (cnt1 != 0) cnt1 <= cnt1 - 1;
    end
  end
  assign spi_done1 = done_m1;

  logic [9:0] words0 [0:4095];
  logic [9:0] addrs0 [0:4095];
  int         scyc0  [0:4095];
  logic [9:0] words1 [0:2047];
  int         n0 = 0, n1 = 0, ndone0 = 0, ndone1 = 0, done_cyc0 = 0;
  int         done_wide = 0, stable_err = 0;
  logic       inflight0 = 1'b0, prev_done0 = 1'b0;
  logic [9:0] hold0 = 10'h0;

  always @(negedge CLK) begin
    if (!RST_N) begin
      inflight0 = 1'b0;
    end else if (spi_start0) begin
      if (n0 < 4096) begin
        words0[n0] = spi_data0;
        addrs0[n0] = gram_addr0;
        scyc0[n0]  = cyc;
      end
      n0++;
      hold0     = spi_data0;
      inflight0 = 1'b1;
    end else if (inflight0 && spi_data0 !== hold0) begin
      stable_err++;
    end
    if (done_m0) inflight0 = 1'b0;
    if (DONE0) begin
      ndone0++;
      done_cyc0 = cyc;
      if (prev_done0) done_wide++;
    end
    prev_done0 = DONE0;
  end

  always @(negedge CLK) begin
    if (RST_N && spi_start1) begin
      if (n1 < 2048) words1[n1] = spi_data1;
      n1++;
    end
    if (DONE1) ndone1++;
  end

  int compared = 0, mismatched = 0;
  int busy_low = 0;
  logic track_busy = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge CLK);
    #1;
  endtask

  function automatic logic [9:0] exp_word(input int idx, input int off);
    int pg, k;
    logic [15:0] a;
    pg = idx / 131;
    k  = idx % 131;
    if (k == 0) return 10'h0B0 | 10'(pg);
    if (k == 1) return 10'(off & 15);
    if (k == 2) return 10'h010 | 10'((off >> 4) & 15);
    a = 16'(pg * 128 + k - 3);
    return {2'b01, a[7:0] ^ 8'h5A};
  endfunction

  task automatic wait_n0(input int target, input int limit, input string tag);
    int k = 0;
    while (n0 < target && k < limit) begin
      step();
      k++;
      if (track_busy && !BUSY0 && !DONE0) busy_low++;
    end
    chk({tag, "_timeout"}, 32'(n0 < target), 0);
  endtask

  task automatic wait_done0(input int target, input int limit, input string tag);
    int k = 0;
    while (ndone0 < target && k < limit) begin
      step();
      k++;
      if (track_busy && !BUSY0 && !DONE0) busy_low++;
    end
    chk({tag, "_timeout"}, 32'(ndone0 < target), 0);
  endtask

  task automatic chk_frame(input string tag, input int which, input int base, input int off);
    int nbad = 0;
    logic [9:0] obs;
    for (int i = 0; i < 1048; i++) begin
      obs = (which == 0) ? words0[base + i] : words1[base + i];
      if (obs !== exp_word(i, off)) nbad++;
    end
    chk(tag, nbad, 0);
  endtask

  int t0, hold_t, done_a, base;

  initial begin
    repeat (3) step();
    chk("rst_busy", BUSY0, 0);
    chk("rst_done", DONE0, 0);
    chk("rst_spi_start", spi_start0, 0);
    chk("rst_spi_data", spi_data0, 0);
    chk("rst_gram_addr", gram_addr0, 0);
    RST_N = 1'b1;
    step();

    // frame A (and the offset-2 frame in parallel)
    track_busy = 1'b1;
    t0 = cyc;
    START0 = 1'b1; START1 = 1'b1;
    step();
    START0 = 1'b0; START1 = 1'b0;
    wait_n0(1, 10, "first_word");
    chk("start_latency", scyc0[0], t0 + 2);
    wait_n0(960, 30000, "frameA_960");
    START0 = 1'b1;
    hold_t = cyc;
    wait_done0(1, 5000, "frameA_done");
    done_a = done_cyc0;
    chk("frameA_count", n0, 1048);
    chk("busy_low_at_done", BUSY0, 0);
    chk("busy_held_in_frame", busy_low, 0);
    track_busy = 1'b0;
    stray_en = 1'b1;
    chk("word0_page", words0[0], 10'h0B0);
    chk("word1_collo", words0[1], 10'h000);
    chk("word2_colhi", words0[2], 10'h010);
    chk("word3_data", words0[3], 10'h15A);
    chk("p3c127_addr", addrs0[523], 10'h1FF);
    chk("p3c127_data", words0[523], 10'h1A5);
    chk("page4_cmd", words0[524], 10'h0B4);
    chk_frame("frameA_words", 0, 0, 0);

    // START held: back-to-back frame B
    wait_n0(1049, 10, "frameB_first");
    chk("b2b_latency", scyc0[1048], done_a + 3);
    chk("frameB_first_word", words0[1048], 10'h0B0);
    while (cyc < hold_t + 3000) step();
    START0 = 1'b0;
    wait_n0(1300, 30000, "frameB_1300");
    START0 = 1'b1;
    step();
    START0 = 1'b0;
    wait_done0(2, 30000, "frameB_done");
    START0 = 1'b1;
    chk("frameB_count", n0, 2096);
    step();
    START0 = 1'b0;
    repeat (60) step();
    chk("no_extra_frame", n0, 2096);
    chk("idle_after_frameB", BUSY0, 0);
    chk("done_pulses", ndone0, 2);
    chk_frame("frameB_words", 0, 1048, 0);
    chk("wait_data_stable", stable_err, 0);
    chk("done_width", done_wide, 0);
    stray_en = 1'b0;

    chk("off2_count", n1, 1048);
    chk("off2_collo", words1[1], 10'h002);
    chk("off2_colhi", words1[2], 10'h010);
    chk("off2_p1_collo", words1[132], 10'h002);
    chk("off2_done", ndone1, 1);
    chk_frame("off2_words", 1, 0, 2);

    // frame C: reset at word 500, then restart
    START0 = 1'b1;
    step();
    START0 = 1'b0;
    wait_n0(2096 + 500, 15000, "frameC_500");
    RST_N = 1'b0;
    #1;
    chk("midrst_busy", BUSY0, 0);
    chk("midrst_done", DONE0, 0);
    chk("midrst_spi_start", spi_start0, 0);
    chk("midrst_spi_data", spi_data0, 0);
    chk("midrst_gram_addr", gram_addr0, 0);
    step();
    RST_N = 1'b1;
    step();
    base = n0;
    t0 = cyc;
    START0 = 1'b1;
    step();
    START0 = 1'b0;
    wait_n0(base + 4, 200, "restart");
    chk("restart_latency", scyc0[base], t0 + 2);
    chk("restart_word0", words0[base], 10'h0B0);
    chk("restart_word3", words0[base + 3], 10'h15A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
